// File: rtl/block_fetch.sv
// block_fetch: on each accepted start, reads one 8x8 pre-IDCT block from SRAM
// and writes it into DPRAM0 starting at DP_OFFSET. Block column, row and plane
// (Y, U, V) are tracked internally and wrap to Y(0,0) after the last V block.
// Optional build macro BLOCK_FETCH_PACK_EN: pack two samples per DPRAM word.
module block_fetch #(
  parameter int unsigned Y_COLS_BLK   = 40,
  parameter int unsigned UV_COLS_BLK  = 20,
  parameter int unsigned ROWS_BLK     = 30,
  parameter int unsigned Y_BASE       = 76800,
  parameter int unsigned U_BASE       = 153600,
  parameter int unsigned V_BASE       = 192000,
  parameter int unsigned DP_OFFSET    = 64,
  parameter int unsigned SRAM_LATENCY = 3
) (
  input  logic        CLOCK_50_I,
  input  logic        Resetn,
  input  logic        start,
  input  logic        restart,
  output logic        busy,
  output logic        done,
  output logic        frame_done,
  output logic [1:0]  plane,
  output logic [5:0]  blk_col,
  output logic [4:0]  blk_row,
  output logic [17:0] SRAM_address,
  input  logic [15:0] SRAM_read_data,
  output logic [6:0]  dp_write_address,
  output logic [31:0] dp_write_data,
  output logic        dp_write_enable
);

  localparam logic [17:0] Y_PITCH    = 18'(8 * Y_COLS_BLK);
  localparam logic [17:0] UV_PITCH   = 18'(8 * UV_COLS_BLK);
  localparam logic [17:0] Y_BASE_A   = 18'(Y_BASE);
  localparam logic [17:0] U_BASE_A   = 18'(U_BASE);
  localparam logic [17:0] V_BASE_A   = 18'(V_BASE);
  localparam logic [5:0]  Y_LAST_COL = 6'(Y_COLS_BLK - 1);
  localparam logic [5:0]  UV_LAST_COL = 6'(UV_COLS_BLK - 1);
  localparam logic [4:0]  LAST_ROW   = 5'(ROWS_BLK - 1);
  localparam logic [6:0]  DP_BASE    = 7'(DP_OFFSET);
  localparam logic [6:0]  DRAIN_LAST = 7'(SRAM_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t r_state, w_next;

  logic [6:0]  r_k;
  logic [1:0]  r_plane;
  logic [5:0]  r_col;
  logic [4:0]  r_row;
  logic [17:0] r_sram_addr;
  logic [6:0]  r_dp_addr;
  logic [31:0] r_dp_data;
  logic        r_dp_we;

  logic [SRAM_LATENCY-1:0]      r_vld;
  logic [SRAM_LATENCY-1:0][5:0] r_idx;

  logic        w_start_ok, w_restart_ok, w_issue;
  logic [1:0]  w_plane;
  logic [5:0]  w_col;
  logic [4:0]  w_row;
  logic [5:0]  w_k;
  logic [7:0]  w_line;
  logic [17:0] w_base, w_offs, w_addr;
  logic        w_last_col, w_last_row, w_last_blk;
  logic        w_out_vld;
  logic [5:0]  w_out_idx;

  // Constant-pitch multiply expressed as a sum of shifted copies of the line.
  function automatic logic [17:0] shift_add(input logic [7:0] line, input logic [17:0] pitch);
    logic [17:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < 18; i++)
      if (pitch[i]) acc = acc + ({10'd0, line} << i);
    return acc;
  endfunction

  assign w_start_ok   = (r_state == S_IDLE) && start;
  assign w_restart_ok = (r_state == S_IDLE) && restart;

  // A same-cycle restart forces the first address of the accepted block to Y(0,0).
  assign w_plane = w_restart_ok ? 2'd0 : r_plane;
  assign w_col   = w_restart_ok ? 6'd0 : r_col;
  assign w_row   = w_restart_ok ? 5'd0 : r_row;
  assign w_k     = (r_state == S_IDLE) ? 6'd0 : r_k[5:0];
  assign w_issue = w_start_ok || ((r_state == S_FETCH) && !r_k[6]);

  assign w_line = {w_row, w_k[5:3]};

  // Sample address: plane base + line * pitch + column offset.
  always_comb begin
    w_base = Y_BASE_A;
    w_offs = shift_add(w_line, Y_PITCH);
    case (w_plane)
      2'd1: begin w_base = U_BASE_A; w_offs = shift_add(w_line, UV_PITCH); end
      2'd2: begin w_base = V_BASE_A; w_offs = shift_add(w_line, UV_PITCH); end
      default: ;
    endcase
    w_addr = w_base + w_offs + {9'd0, w_col, w_k[2:0]};
  end

  assign w_last_col = (r_plane == 2'd0) ? (r_col == Y_LAST_COL) : (r_col == UV_LAST_COL);
  assign w_last_row = (r_row == LAST_ROW);
  assign w_last_blk = (r_plane == 2'd2) && w_last_col && w_last_row;

  // State register.
  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state and status outputs.
  always_comb begin
    w_next     = r_state;
    busy       = 1'b0;
    done       = 1'b0;
    frame_done = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_next = S_FETCH;
      S_FETCH: begin
        busy = 1'b1;
        if (r_k[6]) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (r_k == DRAIN_LAST) w_next = S_DONE;
      end
      S_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        frame_done = w_last_blk;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Sample issue counter in FETCH, reused as the drain counter.
  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) r_k <= '0;
    else begin
      case (r_state)
        S_IDLE:  if (start) r_k <= 7'd1;
        S_FETCH: r_k <= r_k[6] ? 7'd0 : r_k + 7'd1;
        S_DRAIN: r_k <= r_k + 7'd1;
        default: r_k <= '0;
      endcase
    end
  end

  // Registered SRAM read address.
  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn)      r_sram_addr <= '0;
    else if (w_issue) r_sram_addr <= w_addr;
  end

  // Block position: cleared by restart in IDLE, advanced at the end of DONE.
  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      r_plane <= '0;
      r_col   <= '0;
      r_row   <= '0;
    end else if (w_restart_ok) begin
      r_plane <= '0;
      r_col   <= '0;
      r_row   <= '0;
    end else if (r_state == S_DONE) begin
      if (!w_last_col) r_col <= r_col + 6'd1;
      else begin
        r_col <= '0;
        if (!w_last_row) r_row <= r_row + 5'd1;
        else begin
          r_row   <= '0;
          r_plane <= (r_plane == 2'd2) ? 2'd0 : r_plane + 2'd1;
        end
      end
    end
  end

  // Valid/index pipeline matching the SRAM read latency.
  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      r_vld <= '0;
      r_idx <= '0;
    end else begin
      r_vld[0] <= w_issue;
      r_idx[0] <= w_k;
      for (int unsigned i = 1; i < SRAM_LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_idx[i] <= r_idx[i-1];
      end
    end
  end

  assign w_out_vld = r_vld[SRAM_LATENCY-1];
  assign w_out_idx = r_idx[SRAM_LATENCY-1];

`ifdef BLOCK_FETCH_PACK_EN
  logic [15:0] r_even;

  // Hold the even sample; write the pair when the odd sample arrives.
  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      r_even    <= '0;
      r_dp_we   <= 1'b0;
      r_dp_addr <= '0;
      r_dp_data <= '0;
    end else begin
      r_dp_we <= w_out_vld && w_out_idx[0];
      if (w_out_vld && !w_out_idx[0]) r_even <= SRAM_read_data;
      if (w_out_vld && w_out_idx[0]) begin
        r_dp_addr <= DP_BASE + {2'd0, w_out_idx[5:1]};
        r_dp_data <= {r_even, SRAM_read_data};
      end
    end
  end
`else
  // One DPRAM write per returned sample.
  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      r_dp_we   <= 1'b0;
      r_dp_addr <= '0;
      r_dp_data <= '0;
    end else begin
      r_dp_we <= w_out_vld;
      if (w_out_vld) begin
        r_dp_addr <= DP_BASE + {1'b0, w_out_idx};
        r_dp_data <= {16'd0, SRAM_read_data};
      end
    end
  end
`endif

  assign plane            = r_plane;
  assign blk_col          = r_col;
  assign blk_row          = r_row;
  assign SRAM_address     = r_sram_addr;
  assign dp_write_address = r_dp_addr;
  assign dp_write_data    = r_dp_data;
  assign dp_write_enable  = r_dp_we;

endmodule
